// File: rtl/bg_scroll_renderer.sv
// bg_scroll_renderer: scrolled, integer-scaled background renderer.
// Maps each screen pixel (DrawX, DrawY) to a source texel via a power-of-two
// down-scale plus a per-frame wrap-around scroll. It drives the address of an
// external synchronous ROM, translates the returned index through a writable
// palette, and emits registered RGB and an opaque flag 2+ROM_LAT cycles later.
//
// Ports:
//   vga_clk, reset_n       pixel clock, synchronous active-low reset
//   DrawX, DrawY, blank    current pixel position and active-video flag
//   frame_start            one-cycle pulse that latches scroll_x/scroll_y
//   scroll_x, scroll_y     requested texel offsets (ignored if out of range)
//   rom_addr / rom_q       registered ROM address / ROM index data
//   pal_we/waddr/wdata     palette write port ({r,g,b})
//   red, green, blue       registered pixel colour
//   opaque                 pixel valid and index != TRANSPARENT_IDX
module bg_scroll_renderer #(
    parameter int unsigned SRC_W           = 320,
    parameter int unsigned SRC_H           = 240,
    parameter int unsigned SCALE_SHIFT     = 1,
    parameter int unsigned ADDR_W          = 17,
    parameter int unsigned IDX_W           = 4,
    parameter int unsigned COLOR_W         = 4,
    parameter int unsigned ROM_LAT         = 1,
    parameter int unsigned TRANSPARENT_IDX = 0
) (
    input  logic                       vga_clk,
    input  logic                       reset_n,
    input  logic [9:0]                 DrawX,
    input  logic [9:0]                 DrawY,
    input  logic                       blank,
    input  logic                       frame_start,
    input  logic [$clog2(SRC_W)-1:0]   scroll_x,
    input  logic [$clog2(SRC_H)-1:0]   scroll_y,
    output logic [ADDR_W-1:0]          rom_addr,
    input  logic [IDX_W-1:0]           rom_q,
    input  logic                       pal_we,
    input  logic [IDX_W-1:0]           pal_waddr,
    input  logic [3*COLOR_W-1:0]       pal_wdata,
    output logic [COLOR_W-1:0]         red,
    output logic [COLOR_W-1:0]         green,
    output logic [COLOR_W-1:0]         blue,
    output logic                       opaque
);

    localparam int unsigned SXW   = $clog2(SRC_W);
    localparam int unsigned SYW   = $clog2(SRC_H);
    localparam int unsigned PAL_N = 2 ** IDX_W;
    localparam int unsigned CW3   = 3 * COLOR_W;
    localparam int unsigned MAXW1 = (SXW > 10) ? SXW : 10;
    // Wide enough for (texel coordinate + scroll) without overflow.
    localparam int unsigned SUM_W = ((MAXW1 > SYW) ? MAXW1 : SYW) + 1;

    localparam logic [SUM_W-1:0] SRC_W_V = SUM_W'(SRC_W);
    localparam logic [SUM_W-1:0] SRC_H_V = SUM_W'(SRC_H);
    localparam logic [IDX_W-1:0] TRANS_V = IDX_W'(TRANSPARENT_IDX);

    // State
    logic [SXW-1:0]     scroll_x_q, scroll_x_d;
    logic [SYW-1:0]     scroll_y_q, scroll_y_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic [ROM_LAT:0]   vld_q, vld_d;
    logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic               opaque_q, opaque_d;
    logic [CW3-1:0]     pal_q [PAL_N];

    // Stage A combinational signals
    logic [SUM_W-1:0]   ux_c, uy_c, sx_sum_c, sy_sum_c, sx_c, sy_c;
    logic               inrange_c;
    logic [ADDR_W-1:0]  addr_c;
    logic [CW3-1:0]     pal_rd_c;

    // Scroll latch: each axis updates only at frame start and only if in range.
    always_comb begin
        scroll_x_d = scroll_x_q;
        scroll_y_d = scroll_y_q;
        if (frame_start && (SUM_W'(scroll_x) < SRC_W_V)) scroll_x_d = scroll_x;
        if (frame_start && (SUM_W'(scroll_y) < SRC_H_V)) scroll_y_d = scroll_y;
    end

    // Stage A: scale, range check, wrap with a single conditional subtract.
    always_comb begin
        ux_c      = SUM_W'(DrawX >> SCALE_SHIFT);
        uy_c      = SUM_W'(DrawY >> SCALE_SHIFT);
        inrange_c = blank && (ux_c < SRC_W_V) && (uy_c < SRC_H_V);
        sx_sum_c  = ux_c + SUM_W'(scroll_x_q);
        sy_sum_c  = uy_c + SUM_W'(scroll_y_q);
        sx_c      = (sx_sum_c >= SRC_W_V) ? (sx_sum_c - SRC_W_V) : sx_sum_c;
        sy_c      = (sy_sum_c >= SRC_H_V) ? (sy_sum_c - SRC_H_V) : sy_sum_c;
        addr_c    = ADDR_W'(32'(sy_c) * 32'(SRC_W) + 32'(sx_c));
        // Address holds outside the image so the ROM sees no needless toggling.
        rom_addr_d = inrange_c ? addr_c : rom_addr_q;
        // Valid bit travels alongside the address and through the ROM latency.
        vld_d      = {vld_q[ROM_LAT-1:0], inrange_c};
    end

    // Output stage: palette lookup of the returned index.
    always_comb begin
        pal_rd_c = pal_q[rom_q];
        red_d    = '0;
        green_d  = '0;
        blue_d   = '0;
        opaque_d = 1'b0;
        if (vld_q[ROM_LAT]) begin
            {red_d, green_d, blue_d} = pal_rd_c;
            opaque_d                 = (rom_q != TRANS_V);
        end
    end

    // All registers; palette read above sees pre-write contents on a same-cycle write.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            scroll_x_q <= '0;
            scroll_y_q <= '0;
            rom_addr_q <= '0;
            vld_q      <= '0;
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
            opaque_q   <= 1'b0;
            for (int i = 0; i < PAL_N; i++) pal_q[i] <= '0;
        end else begin
            scroll_x_q <= scroll_x_d;
            scroll_y_q <= scroll_y_d;
            rom_addr_q <= rom_addr_d;
            vld_q      <= vld_d;
            red_q      <= red_d;
            green_q    <= green_d;
            blue_q     <= blue_d;
            opaque_q   <= opaque_d;
            if (pal_we) pal_q[pal_waddr] <= pal_wdata;
        end
    end

    assign rom_addr = rom_addr_q;
    assign red      = red_q;
    assign green    = green_q;
    assign blue     = blue_q;
    assign opaque   = opaque_q;

endmodule

// File: tb/tb_bg_scroll_renderer.sv
// Testbench for bg_scroll_renderer: default instance plus a SCALE_SHIFT=0
// instance sharing all stimulus, each with its own 1-cycle-latency ROM model.
module tb_bg_scroll_renderer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  draw_x, draw_y;
    logic        blank, frame_start;
    logic [8:0]  scroll_x;
    logic [7:0]  scroll_y;
    logic        pal_we;
    logic [3:0]  pal_waddr;
    logic [11:0] pal_wdata;

    logic [16:0] rom_addr, rom0_addr;
    logic [3:0]  rom_q, rom0_q;
    logic [3:0]  red, green, blue, red0, green0, blue0;
    logic        opaque, opaque0;

    logic [3:0]  rom_mem [0:131071];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bg_scroll_renderer dut (
        .vga_clk(clk), .reset_n(reset_n), .DrawX(draw_x), .DrawY(draw_y),
        .blank(blank), .frame_start(frame_start), .scroll_x(scroll_x),
        .scroll_y(scroll_y), .rom_addr(rom_addr), .rom_q(rom_q),
        .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
        .red(red), .green(green), .blue(blue), .opaque(opaque)
    );

    bg_scroll_renderer #(.SCALE_SHIFT(0)) dut0 (
        .vga_clk(clk), .reset_n(reset_n), .DrawX(draw_x), .DrawY(draw_y),
        .blank(blank), .frame_start(frame_start), .scroll_x(scroll_x),
        .scroll_y(scroll_y), .rom_addr(rom0_addr), .rom_q(rom0_q),
        .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
        .red(red0), .green(green0), .blue(blue0), .opaque(opaque0)
    );

    // Synchronous ROM, latency 1.
    always @(posedge clk) begin
        rom_q  <= rom_mem[rom_addr];
        rom0_q <= rom_mem[rom0_addr];
    end

    wire [12:0] out_m = {red, green, blue, opaque};
    wire [12:0] out_0 = {red0, green0, blue0, opaque0};

    typedef struct {
        logic [9:0]  dx;
        logic [9:0]  dy;
        logic        bl;
        logic [16:0] a;    // expected rom_addr, default instance
        logic [12:0] o;    // expected {r,g,b,opaque}, default instance
        logic [16:0] a0;   // expected rom_addr, SCALE_SHIFT=0 instance
        logic [12:0] o0;   // expected {r,g,b,opaque}, SCALE_SHIFT=0 instance
    } vec_t;

    vec_t vecs [6];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pal_write(input logic [3:0] idx, input logic [11:0] data);
        pal_we    = 1'b1;
        pal_waddr = idx;
        pal_wdata = data;
        step(1);
        pal_we    = 1'b0;
    endtask

    task automatic set_pix(input logic [9:0] x, input logic [9:0] y, input logic b);
        draw_x = x;
        draw_y = y;
        blank  = b;
    endtask

    task automatic pulse_frame(input logic [8:0] sx, input logic [7:0] sy);
        scroll_x    = sx;
        scroll_y    = sy;
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 131072; i++) rom_mem[i] = 4'd5;
        rom_mem[0]     = 4'd0;
        rom_mem[76799] = 4'd3;

        reset_n = 1'b0; frame_start = 1'b0; pal_we = 1'b0;
        pal_waddr = '0; pal_wdata = '0; scroll_x = '0; scroll_y = '0;
        set_pix(10'd100, 10'd50, 1'b1);
        step(3);
        check("reset_addr", 32'(rom_addr), 32'd0);
        check("reset_out",  32'(out_m),    32'd0);
        reset_n = 1'b1;

        pal_write(4'd5, 12'hF80);
        pal_write(4'd3, 12'h0A5);
        pal_write(4'd0, 12'h123);

        vecs[0] = '{10'd10,  10'd4,   1'b1, 17'd645,   {12'hF80, 1'b1}, 17'd1290, {12'hF80, 1'b1}};
        vecs[1] = '{10'd400, 10'd10,  1'b1, 17'd1800,  {12'hF80, 1'b1}, 17'd1290, 13'd0};
        vecs[2] = '{10'd639, 10'd479, 1'b1, 17'd76799, {12'h0A5, 1'b1}, 17'd1290, 13'd0};
        vecs[3] = '{10'd100, 10'd50,  1'b0, 17'd76799, 13'd0,           17'd1290, 13'd0};
        vecs[4] = '{10'd700, 10'd10,  1'b1, 17'd76799, 13'd0,           17'd1290, 13'd0};
        vecs[5] = '{10'd0,   10'd0,   1'b1, 17'd0,     {12'h123, 1'b0}, 17'd0,    {12'h123, 1'b0}};

        for (int i = 0; i < 6; i++) begin
            set_pix(vecs[i].dx, vecs[i].dy, vecs[i].bl);
            step(1);
            check($sformatf("vec%0d_addr", i),  32'(rom_addr),  32'(vecs[i].a));
            check($sformatf("vec%0d_addr0", i), 32'(rom0_addr), 32'(vecs[i].a0));
            step(2);
            check($sformatf("vec%0d_out", i),   32'(out_m),     32'(vecs[i].o));
            check($sformatf("vec%0d_out0", i),  32'(out_0),     32'(vecs[i].o0));
        end

        // Scroll wrap on both axes.
        set_pix(10'd0, 10'd0, 1'b0);
        pulse_frame(9'd315, 8'd238);
        set_pix(10'd20, 10'd6, 1'b1);
        step(1);
        check("scroll_wrap_addr", 32'(rom_addr), 32'd325);
        // Scroll request without frame_start has no effect.
        scroll_x = 9'd0;
        step(1);
        check("scroll_nolatch_addr", 32'(rom_addr), 32'd325);
        // Out-of-range X keeps previous value; in-range Y latches.
        set_pix(10'd0, 10'd0, 1'b0);
        pulse_frame(9'd400, 8'd0);
        set_pix(10'd20, 10'd6, 1'b1);
        step(1);
        check("scroll_oor_addr", 32'(rom_addr), 32'd965);
        set_pix(10'd0, 10'd0, 1'b0);
        pulse_frame(9'd0, 8'd0);

        // Palette write hazard against the output-stage read of index 5.
        set_pix(10'd10, 10'd4, 1'b1);
        step(3);
        check("hazard_pre", 32'(out_m), 32'({12'hF80, 1'b1}));
        pal_we = 1'b1; pal_waddr = 4'd5; pal_wdata = 12'h00F;
        step(1);
        pal_we = 1'b0;
        check("hazard_old", 32'(out_m), 32'({12'hF80, 1'b1}));
        step(1);
        check("hazard_new", 32'(out_m), 32'({12'h00F, 1'b1}));

        // Reset mid-frame with a valid pixel stream in flight.
        set_pix(10'd100, 10'd50, 1'b1);
        step(3);
        check("mid_pre_out", 32'(out_m), 32'({12'h00F, 1'b1}));
        reset_n = 1'b0;
        step(1);
        check("mid_rst_addr", 32'(rom_addr), 32'd0);
        check("mid_rst_out",  32'(out_m),    32'd0);
        step(1);
        check("mid_rst2_out", 32'(out_m),    32'd0);
        reset_n = 1'b1;
        step(1);
        check("rel1_addr", 32'(rom_addr), 32'd8050);
        check("rel1_out",  32'(out_m),    32'd0);
        step(1);
        check("rel2_out",  32'(out_m),    32'd0);
        step(1);
        check("rel3_out",  32'(out_m),    32'({12'h000, 1'b1}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
